keyboard_decoder: RTL and testbench
===================================

KEYBOARD_DECODER -- requirements
Module: keyboard_decoder

Interface
REQ-001 SHALL have port clock, input, 1 bit: 100 MHz system clock; all state is clocked on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port keyboard_code, input, 8 bits: PS/2 set-2 byte from the keyboard interface, valid only when keyboard_strobe is 1.
REQ-004 SHALL have port keyboard_strobe, input, 1 bit: single-cycle pulse marking one received byte.
REQ-005 SHALL have port read_strobe, input, 1 bit: CPU pop of the FIFO head entry.
REQ-006 SHALL have port read_data, output, 16 bits: head entry, combinational from FIFO storage; bit 15 = not-empty; reads 0 when empty.
REQ-007 SHALL have port fifo_count, output, 5 bits: number of entries held, 0..16.
REQ-008 SHALL have port overflow, output, 1 bit: sticky flag, set when an event is dropped.
REQ-009 SHALL have port clear_overflow, input, 1 bit: clears overflow.

Function
REQ-010 Event word layout SHALL be: [7:0] scan code, [8] extended (E0 prefix), [9] release (F0 prefix), [10] shift, [11] ctrl, [12] alt, [13] caps-lock state, [14] 0, [15] valid.
REQ-011 Prefix FSM SHALL have states IDLE, E0, F0, E0F0, PAUSE and advance only on cycles where keyboard_strobe is 1.
REQ-012 IDLE transitions SHALL be: E0 goes to E0; F0 goes to F0; E1 goes to PAUSE with skip counter = 7; 00, AA, EE, FA, FC, FE and FF are discarded and the FSM stays in IDLE; any other byte emits a make event and stays in IDLE.
REQ-013 State E0 SHALL go to E0F0 on F0; on any other byte it SHALL emit an extended make event and return to IDLE.
REQ-014 State F0 SHALL emit a release event on the next byte; state E0F0 SHALL emit an extended release event on the next byte; both SHALL then return to IDLE.
REQ-015 PAUSE SHALL swallow 7 bytes; on the 7th it SHALL emit code E1 with extended = 1 and release = 0, then return to IDLE.
REQ-016 Modifier tracking:
- shift SHALL be set by make of 12 or 59 and cleared by their release.
- ctrl SHALL track 14 and E0 14.
- alt SHALL track 11 and E0 11.
- shift, ctrl and alt are each the OR of their left/right held bits.
REQ-017 Caps-lock SHALL toggle on make of 58 only when the 58-held bit is clear; typematic repeats SHALL NOT toggle it; release of 58 SHALL clear the held bit.
REQ-018 Modifier bits in an emitted event SHALL reflect state after that event's own update.
REQ-019 An event SHALL be written into the FIFO on the clock edge ending the strobe cycle; fifo_count and read_data SHALL reflect it on the next cycle.
REQ-020 FIFO SHALL be 16 entries with 4-bit wrapping read/write pointers.
REQ-021 read_strobe when empty SHALL be ignored.
REQ-022 A push when fifo_count = 16 SHALL drop the event and set overflow; modifier state SHALL still update.
REQ-023 Simultaneous push and pop SHALL both take effect; when full, the pop frees space first, so the push succeeds and fifo_count stays 16.
REQ-024 If set and clear_overflow occur in the same cycle, set SHALL win.

Reset
REQ-025 Reset SHALL asynchronously force: FSM to IDLE, skip counter 0, all modifier, held and caps bits 0, pointers 0, fifo_count 0, overflow 0, read_data 0.
REQ-026 Reset mid-sequence (e.g. after E0 or within PAUSE) SHALL discard the partial sequence; the next byte is decoded from IDLE.
REQ-027 FIFO storage contents need no reset, because read_data is gated by the valid bit.

Structure
REQ-028 Package keyboard_pkg SHALL hold: the FSM state encoding, scan-code constants (E0, F0, E1, 12, 59, 14, 11, 58), event bit positions, and FIFO depth.
REQ-029 FIFO SHALL be a sub-module kbd_event_fifo: 16x15 bits, with push, pop, full, empty and count.

Verification
REQ-030 Bytes 1C then F0 1C SHALL yield entries 0x801C and 0x821C, with fifo_count = 2.
REQ-031 Bytes 12, 1C, E0 F0 75 SHALL yield 0x8412 (shift make), 0x841C, and 0x8775 (extended release, shift still held).
REQ-032 Bytes 58, 58, F0 58, 58 SHALL toggle caps once per press: caps bit reads 1, 1, 1, then 0.
REQ-033 Bytes E1 14 77 E1 F0 14 F0 77 SHALL yield exactly one entry, 0x81E1; bytes AA and FA SHALL add none.
REQ-034 17 make events with no reads SHALL give fifo_count = 16 and overflow = 1; a pop and push in the same cycle SHALL keep count at 16; clear_overflow SHALL drop overflow to 0.
REQ-035 Reset asserted after E0 and released, then byte 1C, SHALL yield entry 0x801C (not extended).

Source files
------------

// File: rtl/keyboard_pkg.sv
// Shared encodings for the PS/2 set-2 keyboard decoder: FSM states, scan codes,
// event word bit positions and FIFO geometry.
package keyboard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0,
    ST_PAUSE
  } kbd_state_e;

  localparam logic [7:0] CODE_E0     = 8'hE0;
  localparam logic [7:0] CODE_F0     = 8'hF0;
  localparam logic [7:0] CODE_E1     = 8'hE1;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CTRL   = 8'h14;
  localparam logic [7:0] CODE_ALT    = 8'h11;
  localparam logic [7:0] CODE_CAPS   = 8'h58;

  localparam int EVT_EXT   = 8;
  localparam int EVT_REL   = 9;
  localparam int EVT_SHIFT = 10;
  localparam int EVT_CTRL  = 11;
  localparam int EVT_ALT   = 12;
  localparam int EVT_CAPS  = 13;
  localparam int EVT_VALID = 15;
  localparam int EVT_W     = 15;

  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_AW    = 4;
  localparam int FIFO_CW    = 5;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic lshift;
    logic rshift;
    logic lctrl;
    logic rctrl;
    logic lalt;
    logic ralt;
    logic caps_held;
    logic caps;
  } mod_state_t;

  // Keyboard status/ack bytes that never carry a key event.
  function automatic logic is_discard(input logic [7:0] code);
    return code inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  endfunction

endpackage

// File: rtl/keyboard_decoder_fifo.sv
// 16-entry event FIFO; a pop frees space before a same-cycle push is judged.
module kbd_event_fifo
  import keyboard_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic [EVT_W-1:0]   wr_data,
  input  logic               pop,
  output logic [EVT_W-1:0]   rd_data,
  output logic               full,
  output logic               empty,
  output logic [FIFO_CW-1:0] count
);

  logic [EVT_W-1:0]   mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FIFO_CW'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      count <= count + FIFO_CW'(do_push) - FIFO_CW'(do_pop);
    end
  end

  // Storage is unreset; consumers gate it with empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/keyboard_decoder.sv
// PS/2 set-2 byte decoder: prefix FSM, modifier/caps tracking and event FIFO.
//   state    | meaning
//   ST_IDLE  | waiting for the first byte of a sequence
//   ST_E0    | E0 seen, next byte is an extended make unless it is F0
//   ST_F0    | F0 seen, next byte is a release
//   ST_E0F0  | E0 F0 seen, next byte is an extended release
//   ST_PAUSE | swallowing the Pause sequence, skip counts bytes left
module keyboard_decoder
  import keyboard_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  keyboard_code,
  input  logic        keyboard_strobe,
  input  logic        read_strobe,
  output logic [15:0] read_data,
  output logic [4:0]  fifo_count,
  output logic        overflow,
  input  logic        clear_overflow
);

  kbd_state_e       state, state_nxt;
  logic [2:0]       skip, skip_nxt;
  mod_state_t       mods, mods_nxt;
  logic             emit;
  logic             ev_ext;
  logic             ev_rel;
  logic [7:0]       ev_code;
  logic [EVT_W-1:0] ev_word;
  logic [EVT_W-1:0] fifo_rd;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip     <= '0;
      mods     <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      skip  <= skip_nxt;
      mods  <= mods_nxt;
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip;
    emit      = 1'b0;
    ev_ext    = 1'b0;
    ev_rel    = 1'b0;
    ev_code   = keyboard_code;
    if (keyboard_strobe) begin
      case (state)
        ST_IDLE: begin
          if (keyboard_code == CODE_E0)      state_nxt = ST_E0;
          else if (keyboard_code == CODE_F0) state_nxt = ST_F0;
          else if (keyboard_code == CODE_E1) begin
            state_nxt = ST_PAUSE;
            skip_nxt  = PAUSE_SKIP;
          end else if (!is_discard(keyboard_code)) emit = 1'b1;
        end
        ST_E0: begin
          if (keyboard_code == CODE_F0) state_nxt = ST_E0F0;
          else begin
            emit      = 1'b1;
            ev_ext    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_F0: begin
          emit      = 1'b1;
          ev_rel    = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_E0F0: begin
          emit      = 1'b1;
          ev_ext    = 1'b1;
          ev_rel    = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_PAUSE: begin
          if (skip <= 3'd1) begin
            emit      = 1'b1;
            ev_ext    = 1'b1;
            ev_code   = CODE_E1;
            skip_nxt  = '0;
            state_nxt = ST_IDLE;
          end else begin
            skip_nxt = skip - 3'd1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Held bits follow make/release; caps only toggles on a fresh press.
  always_comb begin
    mods_nxt = mods;
    if (emit) begin
      case (ev_code)
        CODE_LSHIFT: mods_nxt.lshift = !ev_rel;
        CODE_RSHIFT: mods_nxt.rshift = !ev_rel;
        CODE_CTRL: begin
          if (ev_ext) mods_nxt.rctrl = !ev_rel;
          else        mods_nxt.lctrl = !ev_rel;
        end
        CODE_ALT: begin
          if (ev_ext) mods_nxt.ralt = !ev_rel;
          else        mods_nxt.lalt = !ev_rel;
        end
        CODE_CAPS: begin
          if (!ev_rel && !mods.caps_held) mods_nxt.caps = !mods.caps;
          mods_nxt.caps_held = !ev_rel;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ev_word            = '0;
    ev_word[7:0]       = ev_code;
    ev_word[EVT_EXT]   = ev_ext;
    ev_word[EVT_REL]   = ev_rel;
    ev_word[EVT_SHIFT] = mods_nxt.lshift | mods_nxt.rshift;
    ev_word[EVT_CTRL]  = mods_nxt.lctrl | mods_nxt.rctrl;
    ev_word[EVT_ALT]   = mods_nxt.lalt | mods_nxt.ralt;
    ev_word[EVT_CAPS]  = mods_nxt.caps;
  end

  assign drop = emit && fifo_full && !read_strobe;

  kbd_event_fifo u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (emit),
    .wr_data (ev_word),
    .pop     (read_strobe),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    read_data = '0;
    if (!fifo_empty) begin
      read_data[EVT_W-1:0] = fifo_rd;
      read_data[EVT_VALID] = 1'b1;
    end
  end

endmodule

// File: tb/tb_keyboard_decoder.sv
// Bench for keyboard_decoder: byte-sequence reference model compared every cycle,
// directed sequences with literal expectations, then randomized traffic.
module tb_keyboard_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  keyboard_code = 8'h00;
  logic        keyboard_strobe = 1'b0;
  logic        read_strobe = 1'b0;
  logic        clear_overflow = 1'b0;
  logic [15:0] read_data;
  logic [4:0]  fifo_count;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  keyboard_decoder dut (
    .clock           (clock),
    .reset           (reset),
    .keyboard_code   (keyboard_code),
    .keyboard_strobe (keyboard_strobe),
    .read_strobe     (read_strobe),
    .read_data       (read_data),
    .fifo_count      (fifo_count),
    .overflow        (overflow),
    .clear_overflow  (clear_overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending bytes of the current sequence, event queue, held keys.
  logic [7:0]  pend [$];
  logic [15:0] q [$];
  bit          held [512];
  bit          m_caps;
  bit          m_ovf;
  bit          ev;
  bit          dropped;
  bit          e_ext;
  bit          e_rel;
  logic [7:0]  e_code;
  int          k;

  function automatic bit is_noise(input logic [7:0] c);
    return c inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  endfunction

  function automatic bit waiting_prefix();
    if (pend.size() == 1) return (pend[0] == 8'hE0) || (pend[0] == 8'hF0);
    if (pend.size() == 2) return (pend[0] == 8'hE0) && (pend[1] == 8'hF0);
    return 1'b0;
  endfunction

  // Shift and caps keys are identified by code alone; ctrl/alt sides by the E0 prefix.
  function automatic int key_of(input logic [7:0] c, input bit ext);
    if (c == 8'h12 || c == 8'h59 || c == 8'h58) return int'(c);
    return ext ? 256 + int'(c) : int'(c);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pend.delete();
      q.delete();
      foreach (held[i]) held[i] = 1'b0;
      m_caps = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      ev      = 1'b0;
      dropped = 1'b0;
      if (keyboard_strobe) begin
        pend.push_back(keyboard_code);
        if (pend[0] == 8'hE1) begin
          if (pend.size() == 8) begin
            ev = 1'b1; e_code = 8'hE1; e_ext = 1'b1; e_rel = 1'b0;
          end
        end else if (pend.size() == 1 && is_noise(keyboard_code)) begin
          pend.delete();
        end else if (!waiting_prefix()) begin
          ev     = 1'b1;
          e_code = keyboard_code;
          e_ext  = (pend[0] == 8'hE0);
          e_rel  = (pend.size() >= 2) && (pend[pend.size()-2] == 8'hF0);
        end
        if (ev) pend.delete();
      end
      if (ev) begin
        k = key_of(e_code, e_ext);
        if (e_rel) held[k] = 1'b0;
        else begin
          if (k == 'h58 && !held[k]) m_caps = !m_caps;
          held[k] = 1'b1;
        end
      end
      if (read_strobe && q.size() > 0) q.delete(0);
      if (ev) begin
        if (q.size() < 16)
          q.push_back({1'b1, 1'b0, m_caps,
                       held['h11] | held['h111],
                       held['h14] | held['h114],
                       held['h12] | held['h59],
                       e_rel, e_ext, e_code});
        else begin
          m_ovf   = 1'b1;
          dropped = 1'b1;
        end
      end
      if (clear_overflow && !dropped) m_ovf = 1'b0;
    end
  end

  always @(negedge clock) begin
    check("fifo_count", 32'(fifo_count), 32'(q.size()));
    check("read_data", 32'(read_data), (q.size() > 0) ? 32'(q[0]) : 32'h0);
    check("overflow", 32'(overflow), 32'(m_ovf));
  end

  task automatic cyc(input bit s, input logic [7:0] c, input bit r, input bit clr);
    keyboard_strobe = s;
    keyboard_code   = c;
    read_strobe     = r;
    clear_overflow  = clr;
    @(posedge clock);
    #1;
    keyboard_strobe = 1'b0;
    read_strobe     = 1'b0;
    clear_overflow  = 1'b0;
  endtask

  task automatic sb(input logic [7:0] c);
    cyc(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic pop_chk(input string name, input logic [15:0] exp);
    check(name, 32'(read_data), 32'(exp));
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  logic [7:0] mod_pool [5];
  logic [7:0] noise_pool [7];

  initial begin
    mod_pool   = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h58};
    noise_pool = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_read_data", 32'(read_data), 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    @(posedge clock);
    #1;

    sb(8'h1C); sb(8'hF0); sb(8'h1C);
    check("make_release_count", 32'(fifo_count), 32'd2);
    pop_chk("make_1c", 16'h801C);
    pop_chk("release_1c", 16'h821C);

    sb(8'h12); sb(8'h1C); sb(8'hE0); sb(8'hF0); sb(8'h75);
    pop_chk("shift_make", 16'h8412);
    pop_chk("shifted_1c", 16'h841C);
    pop_chk("ext_release_75", 16'h8775);
    sb(8'hF0); sb(8'h12);
    pop_chk("shift_release", 16'h8212);

    sb(8'h58); sb(8'h58); sb(8'hF0); sb(8'h58); sb(8'h58);
    pop_chk("caps_press1", 16'hA058);
    pop_chk("caps_repeat", 16'hA058);
    pop_chk("caps_release", 16'hA258);
    pop_chk("caps_press2", 16'h8058);
    sb(8'hF0); sb(8'h58);
    pop_chk("caps_release2", 16'h8258);

    sb(8'hE1); sb(8'h14); sb(8'h77); sb(8'hE1);
    sb(8'hF0); sb(8'h14); sb(8'hF0); sb(8'h77);
    sb(8'hAA); sb(8'hFA);
    check("pause_count", 32'(fifo_count), 32'd1);
    pop_chk("pause_event", 16'h81E1);

    sb(8'hE0); sb(8'h14); sb(8'h14); sb(8'hE0); sb(8'hF0); sb(8'h14);
    sb(8'hF0); sb(8'h14); sb(8'h11); sb(8'hF0); sb(8'h11);
    pop_chk("rctrl_make", 16'h8914);
    pop_chk("lctrl_make", 16'h8814);
    pop_chk("rctrl_release", 16'h8B14);
    pop_chk("lctrl_release", 16'h8214);
    pop_chk("alt_make", 16'h9011);
    pop_chk("alt_release", 16'h8211);

    sb(8'hE0);
    pulse_reset();
    sb(8'h1C);
    pop_chk("reset_after_e0", 16'h801C);
    sb(8'hE1); sb(8'h14);
    pulse_reset();
    sb(8'h1C);
    pop_chk("reset_in_pause", 16'h801C);

    repeat (17) sb(8'h1C);
    check("full_count", 32'(fifo_count), 32'd16);
    check("full_overflow", 32'(overflow), 32'd1);
    cyc(1'b1, 8'h2B, 1'b1, 1'b0);
    check("pop_push_full_count", 32'(fifo_count), 32'd16);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("overflow_cleared", 32'(overflow), 32'd0);
    cyc(1'b1, 8'h2B, 1'b0, 1'b1);
    check("set_beats_clear", 32'(overflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (15) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    pop_chk("last_after_wrap", 16'h802B);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("pop_empty_count", 32'(fifo_count), 32'd0);

    for (int n = 0; n < 4000; n++) begin
      int    r;
      bit    s;
      logic [7:0] b;
      if ($urandom_range(0, 399) == 0) pulse_reset();
      r = int'($urandom_range(0, 19));
      if (r < 2)       b = 8'hE0;
      else if (r < 4)  b = 8'hF0;
      else if (r < 8)  b = mod_pool[$urandom_range(0, 4)];
      else if (r == 8) b = 8'hE1;
      else if (r < 11) b = noise_pool[$urandom_range(0, 6)];
      else             b = 8'($urandom);
      s = ($urandom_range(0, 9) < 6);
      cyc(s, b, ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0));
    end

    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
